// File: rtl/control_entrada_pkg.sv
// control_entrada_pkg: shared state encoding and default sizing for the
// operator-input front end (control_entrada and antirrebote).
package control_entrada_pkg;

    localparam int unsigned DefDebounceCnt = 250000;
    localparam int unsigned DefCntW        = 18;
    localparam int unsigned EstadoW        = 3;

    typedef enum logic [EstadoW-1:0] {
        StIdle   = 3'd0,
        StCampoT = 3'd1,
        StCampoP = 3'd2,
        StCampoB = 3'd3,
        StFin    = 3'd4
    } estado_e;

endpackage

// File: rtl/control_entrada_if.sv
// control_entrada_if: strobes, captured data and state seen by the
// programming FSM / register pair downstream of control_entrada.
interface control_entrada_if;
    import control_entrada_pkg::*;

    logic               iniciar;
    logic               terminar;
    logic               validat;
    logic               validap;
    logic               validab;
    logic [4:0]         dd;
    logic               d;
    logic               d1;
    logic [EstadoW-1:0] estado;

    modport master (
        output iniciar, terminar, validat, validap, validab, dd, d, d1, estado
    );

    modport slave (
        input iniciar, terminar, validat, validap, validab, dd, d, d1, estado
    );

endinterface

// File: rtl/antirrebote.sv
// antirrebote: 2-flop synchronizer, optional debounce counter and rising-edge
// pulse for one raw push-button.
// Build option: CONTROL_ENTRADA_DEBOUNCE_EN enables the debounce counter;
// without it the synced level is taken as the accepted level.
module antirrebote
    import control_entrada_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = DefDebounceCnt,
    parameter int unsigned CNT_W        = DefCntW
) (
    input  logic clk,
    input  logic reset,
    input  logic boton,
    output logic pulso
);

    logic [1:0] sync_q;
    logic       nivel;
    logic       nivel_prev_q;
    logic       pulso_q;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], boton};
        end
    end

`ifdef CONTROL_ENTRADA_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             estable_q, estable_d;

    // Count consecutive cycles of disagreement; flip the accepted level on the last one
    always_comb begin
        cnt_d     = '0;
        estable_d = estable_q;
        if (sync_q[1] != estable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
                estable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce counter and accepted level registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            estable_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            estable_q <= estable_d;
        end
    end

    assign nivel = estable_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{DEBOUNCE_CNT, CNT_W};
    assign nivel      = sync_q[1];
`endif

    // Registered one-cycle pulse on each accepted rising level
    always_ff @(posedge clk) begin
        if (reset) begin
            nivel_prev_q <= 1'b0;
            pulso_q      <= 1'b0;
        end else begin
            nivel_prev_q <= nivel;
            pulso_q      <= nivel & ~nivel_prev_q;
        end
    end

    assign pulso = pulso_q;

endmodule

// File: rtl/control_entrada.sv
// control_entrada: conditions the three buttons and the data switches and
// enforces the entry order t -> p -> b, emitting registered one-cycle strobes.
// Build option: CONTROL_ENTRADA_DEBOUNCE_EN (passed down to antirrebote).
module control_entrada
    import control_entrada_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT = DefDebounceCnt,
    parameter int unsigned CNT_W        = DefCntW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn_iniciar,
    input  logic                     btn_ok,
    input  logic                     btn_terminar,
    input  logic [4:0]               sw_dato,
    input  logic                     sw_d,
    input  logic                     sw_d1,
    control_entrada_if.master        ctrl
);

    logic p_iniciar, p_ok, p_terminar;

    antirrebote #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .CNT_W(CNT_W)) u_ab_iniciar (
        .clk   (clk),
        .reset (reset),
        .boton (btn_iniciar),
        .pulso (p_iniciar)
    );

    antirrebote #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .CNT_W(CNT_W)) u_ab_ok (
        .clk   (clk),
        .reset (reset),
        .boton (btn_ok),
        .pulso (p_ok)
    );

    antirrebote #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .CNT_W(CNT_W)) u_ab_terminar (
        .clk   (clk),
        .reset (reset),
        .boton (btn_terminar),
        .pulso (p_terminar)
    );

    // Switch bus packed as {dato[4:0], d, d1}
    logic [6:0] sw_s1_q, sw_s2_q;

    // Two-stage synchronizer for the switches; capture uses the second stage
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= {sw_dato, sw_d, sw_d1};
            sw_s2_q <= sw_s1_q;
        end
    end

    estado_e    estado_q, estado_d;
    logic       iniciar_q, iniciar_d;
    logic       terminar_q, terminar_d;
    logic       validat_q, validat_d;
    logic       validap_q, validap_d;
    logic       validab_q, validab_d;
    logic [4:0] dd_q, dd_d;
    logic       d_q, d_d;
    logic       d1_q, d1_d;

    // Next state, strobes and captures; terminar outranks iniciar outranks ok
    always_comb begin
        estado_d   = estado_q;
        iniciar_d  = 1'b0;
        terminar_d = 1'b0;
        validat_d  = 1'b0;
        validap_d  = 1'b0;
        validab_d  = 1'b0;
        dd_d       = dd_q;
        d_d        = d_q;
        d1_d       = d1_q;
        if (estado_q == StIdle) begin
            if (p_iniciar) begin
                iniciar_d = 1'b1;
                estado_d  = StCampoT;
            end
        end else if (p_terminar) begin
            // Abort or normal end: captured data is kept
            terminar_d = 1'b1;
            estado_d   = StIdle;
        end else if (p_ok) begin
            case (estado_q)
                StCampoT: begin
                    dd_d      = sw_s2_q[6:2];
                    validat_d = 1'b1;
                    estado_d  = StCampoP;
                end
                StCampoP: begin
                    d_d       = sw_s2_q[1];
                    validap_d = 1'b1;
                    estado_d  = StCampoB;
                end
                StCampoB: begin
                    d1_d      = sw_s2_q[0];
                    validab_d = 1'b1;
                    estado_d  = StFin;
                end
                default: ;
            endcase
        end
    end

    // State, strobe and data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= StIdle;
            iniciar_q  <= 1'b0;
            terminar_q <= 1'b0;
            validat_q  <= 1'b0;
            validap_q  <= 1'b0;
            validab_q  <= 1'b0;
            dd_q       <= '0;
            d_q        <= 1'b0;
            d1_q       <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            iniciar_q  <= iniciar_d;
            terminar_q <= terminar_d;
            validat_q  <= validat_d;
            validap_q  <= validap_d;
            validab_q  <= validab_d;
            dd_q       <= dd_d;
            d_q        <= d_d;
            d1_q       <= d1_d;
        end
    end

    assign ctrl.iniciar  = iniciar_q;
    assign ctrl.terminar = terminar_q;
    assign ctrl.validat  = validat_q;
    assign ctrl.validap  = validap_q;
    assign ctrl.validab  = validab_q;
    assign ctrl.dd       = dd_q;
    assign ctrl.d        = d_q;
    assign ctrl.d1       = d1_q;
    assign ctrl.estado   = estado_q;

endmodule

// File: tb/tb_control_entrada.sv
// tb_control_entrada: directed + random stimulus against a run-length /
// session reference model. Honours CONTROL_ENTRADA_DEBOUNCE_EN.
`timescale 1ns/1ps
module tb_control_entrada;
    import control_entrada_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 3;
`ifdef CONTROL_ENTRADA_DEBOUNCE_EN
    localparam int RunMin    = N;
    localparam int Lat       = N + 3;
    localparam int BounceSt  = 2;
    localparam int BounceIdx = 1;
`else
    localparam int RunMin    = 1;
    localparam int Lat       = 3;
    localparam int BounceSt  = 4;
    localparam int BounceIdx = 3;
`endif
    localparam int H = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_iniciar = 1'b0, btn_ok = 1'b0, btn_terminar = 1'b0;
    logic [4:0] sw_dato = '0;
    logic       sw_d = 1'b0, sw_d1 = 1'b0;

    control_entrada_if ctrl ();

    control_entrada #(.DEBOUNCE_CNT(N), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_iniciar  (btn_iniciar),
        .btn_ok       (btn_ok),
        .btn_terminar (btn_terminar),
        .sw_dato      (sw_dato),
        .sw_d         (sw_d),
        .sw_d1        (sw_d1),
        .ctrl         (ctrl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- reference model (runs at each sampling edge) ----------------
    // A button level is accepted once the raw input has held a new value for RunMin
    // consecutive sampling edges; an accepted rise acts Lat edges after the run began.
    int         edge_n = 10;
    bit         model_ok = 1'b0;
    logic [6:0] sw_hist [H];
    bit   [2:0] pend [H];
    bit   [2:0] acc, run_val, raw, p;
    int         run_len [3];
    int         run_start [3];
    int         m_st = 0;
    logic       m_ini = 0, m_term = 0, m_vt = 0, m_vp = 0, m_vb = 0;
    logic [4:0] m_dd = '0;
    logic       m_d = 0, m_d1 = 0;
    logic [6:0] cap;

    always @(posedge clk) begin
        edge_n++;
        raw = {btn_terminar, btn_ok, btn_iniciar};
        {m_ini, m_term, m_vt, m_vp, m_vb} = '0;
        if (reset) begin
            model_ok = 1'b1;
            sw_hist[edge_n % H] = '0;
            for (int i = 0; i < H; i++) pend[i] = '0;
            acc = '0;
            run_val = '0;
            for (int b = 0; b < 3; b++) run_len[b] = RunMin;
            m_st = 0;
            m_dd = '0;
            m_d  = 1'b0;
            m_d1 = 1'b0;
        end else begin
            sw_hist[edge_n % H] = {sw_dato, sw_d, sw_d1};
            for (int b = 0; b < 3; b++) begin
                if (raw[b] == run_val[b]) begin
                    run_len[b]++;
                end else begin
                    run_val[b]   = raw[b];
                    run_len[b]   = 1;
                    run_start[b] = edge_n;
                end
                if (run_len[b] == RunMin && run_val[b] != acc[b]) begin
                    acc[b] = run_val[b];
                    if (run_val[b]) pend[(run_start[b] + Lat) % H][b] = 1'b1;
                end
            end
            p = pend[edge_n % H];
            pend[edge_n % H] = '0;
            cap = sw_hist[(edge_n - 2) % H];
            if (m_st != 0 && p[2]) begin
                m_term = 1'b1;
                m_st   = 0;
            end else if (m_st == 0 && p[0]) begin
                m_ini = 1'b1;
                m_st  = 1;
            end else if (p[1] && m_st >= 1 && m_st <= 3) begin
                if (m_st == 1) begin
                    m_vt = 1'b1;
                    m_dd = cap[6:2];
                end else if (m_st == 2) begin
                    m_vp = 1'b1;
                    m_d  = cap[1];
                end else begin
                    m_vb = 1'b1;
                    m_d1 = cap[0];
                end
                m_st++;
            end
        end
    end

    // ---------------- per-cycle comparison and strobe log ----------------
    // index: 0 iniciar, 1 validat, 2 validap, 3 validab, 4 terminar
    int cnt [5] = '{0, 0, 0, 0, 0};
    int last_edge [5] = '{0, 0, 0, 0, 0};
    logic [14:0] obs_v, exp_v;

    always @(negedge clk) begin
        if (model_ok) begin
            obs_v = {ctrl.iniciar, ctrl.terminar, ctrl.validat, ctrl.validap, ctrl.validab,
                     ctrl.dd, ctrl.d, ctrl.d1, ctrl.estado};
            exp_v = {m_ini, m_term, m_vt, m_vp, m_vb, m_dd, m_d, m_d1, 3'(m_st)};
            checks++;
            assert (obs_v === exp_v) else begin
                failures++;
                $error("FAIL cycle edge=%0d observed=%h expected=%h", edge_n, obs_v, exp_v);
            end
            if (ctrl.iniciar === 1'b1)  begin cnt[0]++; last_edge[0] = edge_n; end
            if (ctrl.validat === 1'b1)  begin cnt[1]++; last_edge[1] = edge_n; end
            if (ctrl.validap === 1'b1)  begin cnt[2]++; last_edge[2] = edge_n; end
            if (ctrl.validab === 1'b1)  begin cnt[3]++; last_edge[3] = edge_n; end
            if (ctrl.terminar === 1'b1) begin cnt[4]++; last_edge[4] = edge_n; end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rnd_sw = 1'b0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_sw) {sw_dato, sw_d, sw_d1} = 7'($urandom);
        end
    endtask

    // m = {terminar, ok, iniciar}
    task automatic press(input bit [2:0] m, input int hold, input int gap);
        {btn_terminar, btn_ok, btn_iniciar} = m;
        tick(hold);
        {btn_terminar, btn_ok, btn_iniciar} = '0;
        tick(gap);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int total();
        return cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4];
    endfunction

    int e0, c0, c1, tc;
    logic [4:0] dd_keep;
    localparam int S = Lat + 4;

    initial begin
        // Reset state
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        chk("rst_estado", 32'(ctrl.estado), 0);
        chk("rst_outs", 32'({ctrl.iniciar, ctrl.terminar, ctrl.validat, ctrl.validap,
                             ctrl.validab, ctrl.dd, ctrl.d, ctrl.d1}), 0);
        tick(2);

        // iniciar held 20 cycles: one strobe, fixed latency
        e0 = edge_n + 1;
        c0 = cnt[0];
        btn_iniciar = 1'b1;
        tick(20);
        btn_iniciar = 1'b0;
        tick(S);
        chk("ini_count", cnt[0] - c0, 1);
        chk("ini_latency", last_edge[0] - e0, Lat);
        chk("ini_estado", 32'(ctrl.estado), 1);

        // Full session with fixed switches
        press(3'b100, S, S);
        chk("pre_session_idle", 32'(ctrl.estado), 0);
        sw_dato = 5'b10110;
        sw_d    = 1'b1;
        sw_d1   = 1'b0;
        tick(3);
        press(3'b001, S, S);
        press(3'b010, S, S);
        chk("sess_dd", 32'(ctrl.dd), 22);
        chk("sess_st_p", 32'(ctrl.estado), 2);
        press(3'b010, S, S);
        chk("sess_d", 32'(ctrl.d), 1);
        press(3'b010, S, S);
        chk("sess_d1", 32'(ctrl.d1), 0);
        chk("sess_st_fin", 32'(ctrl.estado), 4);
        press(3'b100, S, S);
        chk("sess_st_end", 32'(ctrl.estado), 0);
        chk("sess_order", 32'(last_edge[0] < last_edge[1] && last_edge[1] < last_edge[2] &&
                             last_edge[2] < last_edge[3] && last_edge[3] < last_edge[4]), 1);

        // Bouncing ok in CAMPO_T
        press(3'b001, S, S);
        c1 = cnt[1];
        for (int i = 0; i < 5; i++) begin
            if (i == 4) e0 = edge_n + 1;
            btn_ok = (i % 2 == 0);
            tick(2);
        end
        btn_ok = 1'b1;
        tick(S + 2);
        btn_ok = 1'b0;
        tick(S);
        chk("bounce_validat", cnt[1] - c1, 1);
        chk("bounce_latency", last_edge[BounceIdx] - e0, Lat);
        chk("bounce_estado", 32'(ctrl.estado), BounceSt);
        press(3'b100, S, S);

        // Abort in CAMPO_P keeps dd
        sw_dato = 5'(($urandom % 31) + 1);
        dd_keep = sw_dato;
        tick(3);
        press(3'b001, S, S);
        press(3'b010, S, S);
        c1 = cnt[2];
        tc = cnt[4];
        press(3'b100, S, S);
        chk("abort_term", cnt[4] - tc, 1);
        chk("abort_no_vp", cnt[2] - c1, 0);
        chk("abort_estado", 32'(ctrl.estado), 0);
        chk("abort_dd", 32'(ctrl.dd), 32'(dd_keep));

        // Simultaneous terminar + ok in CAMPO_T
        press(3'b001, S, S);
        c1 = cnt[1];
        tc = cnt[4];
        press(3'b110, S, S);
        chk("simul_term", cnt[4] - tc, 1);
        chk("simul_no_vt", cnt[1] - c1, 0);
        chk("simul_estado", 32'(ctrl.estado), 0);

        // ok in IDLE is ignored
        c0 = total();
        press(3'b010, S, S);
        chk("idle_ok", total() - c0, 0);
        // iniciar in CAMPO_B is ignored
        press(3'b001, S, S);
        press(3'b010, S, S);
        press(3'b010, S, S);
        c0 = total();
        press(3'b001, S, S);
        chk("campob_ini", total() - c0, 0);
        chk("campob_estado", 32'(ctrl.estado), 3);

        // Reset mid-CAMPO_B
        tc = cnt[4];
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("midrst_outs", 32'({ctrl.iniciar, ctrl.terminar, ctrl.validat, ctrl.validap,
                               ctrl.validab, ctrl.dd, ctrl.d, ctrl.d1}), 0);
        chk("midrst_estado", 32'(ctrl.estado), 0);
        tick(S);
        chk("midrst_no_term", cnt[4] - tc, 0);

        // Random presses, holds, gaps and switches; checked cycle by cycle
        rnd_sw = 1'b1;
        repeat (60) begin
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
            press(3'($urandom_range(1, 7)), $urandom_range(1, S + 2), $urandom_range(1, S + 2));
        end
        rnd_sw = 1'b0;
        {btn_terminar, btn_ok, btn_iniciar} = '0;
        tick(S + 4);
        chk("final_estado", 32'(ctrl.estado), 32'(m_st));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
